// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared states, port ids, constants and lane-merge helper for the RAM port arbiter
package ram_port_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, RSP, RMW_WR} state_t;
    typedef enum logic {PORT_IF = 1'b0, PORT_D = 1'b1} port_t;
    localparam logic [3:0] BE_FULL = 4'hF;
    localparam int RAM_DEPTH_WORDS = 2048;
    function automatic logic [31:0] merge_lanes(input logic [31:0] new_data, input logic [31:0] old_data,
                                                input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: one core-side memory port (request, store fields, grant and response)
interface ram_port_arbiter_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/ram_port_arbiter_rr.sv
// ram_port_arbiter_rr: 2-way round-robin grant; the port not granted last wins a conflict
module ram_port_arbiter_rr
    import ram_port_arbiter_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en,
    input  logic req_if,
    input  logic req_d,
    output logic gnt_if,
    output logic gnt_d
);
    port_t last_grant;
    always_comb begin
        gnt_d  = rst_n_i & en & req_d & (~req_if | last_grant == PORT_IF);
        gnt_if = rst_n_i & en & req_if & (~req_d | last_grant == PORT_D);
    end
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) last_grant <= PORT_IF;
        else if (gnt_if | gnt_d) last_grant <= gnt_d ? PORT_D : PORT_IF;
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares a single-port 32-bit RAM between fetch and load/store, with RMW for partial stores
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int DEPTH_WORDS = RAM_DEPTH_WORDS
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    ram_port_arbiter_if.slave fetch,
    ram_port_arbiter_if.slave data,
    output logic              ram_we_o,
    output logic [31:0]       ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i
);
    state_t      state;
    logic        rv_if, rv_d, rsp_err, rsp_rd;
    logic [29:0] rmw_word, sel_word;
    logic [31:0] rmw_wdata;
    logic [3:0]  rmw_be;
    logic        gnt_if, gnt_d, accept, oor, partial, full_wr;
    logic        unused;
    ram_port_arbiter_rr u_rr (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en      (state != RMW_WR),
        .req_if  (fetch.req),
        .req_d   (data.req),
        .gnt_if  (gnt_if),
        .gnt_d   (gnt_d)
    );
    always_comb begin
        accept      = gnt_if | gnt_d;
        sel_word    = gnt_d ? data.addr[31:2] : fetch.addr[31:2];
        oor         = {2'b0, sel_word} >= 32'(DEPTH_WORDS);
        partial     = gnt_d & data.we & data.be != BE_FULL & data.be != 4'h0;
        full_wr     = gnt_d & data.we & data.be == BE_FULL & ~oor;
        ram_we_o    = rst_n_i & (state == RMW_WR | full_wr);
        ram_addr_o  = state == RMW_WR ? {2'b0, rmw_word} : accept ? {2'b0, sel_word} : 32'h0;
        ram_wdata_o = state == RMW_WR ? merge_lanes(rmw_wdata, ram_rdata_i, rmw_be) : full_wr ? data.wdata : 32'h0;
    end
    assign fetch.gnt    = gnt_if;
    assign data.gnt     = gnt_d;
    assign fetch.rvalid = rv_if;
    assign data.rvalid  = rv_d;
    assign fetch.err    = rv_if & rsp_err;
    assign data.err     = rv_d & rsp_err;
    assign fetch.rdata  = rv_if & rsp_rd ? ram_rdata_i : 32'h0;
    assign data.rdata   = rv_d & rsp_rd ? ram_rdata_i : 32'h0;
    assign unused       = ^{fetch.addr[1:0], data.addr[1:0], fetch.we, fetch.be, fetch.wdata};
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            rv_if     <= 1'b0;
            rv_d      <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rd    <= 1'b0;
            rmw_word  <= '0;
            rmw_wdata <= '0;
            rmw_be    <= '0;
        end else if (state == RMW_WR) begin
            state   <= RSP;
            rv_d    <= 1'b1;
            rsp_err <= 1'b0;
            rsp_rd  <= 1'b0;
        end else if (partial & ~oor) begin
            state     <= RMW_WR;
            rv_if     <= 1'b0;
            rv_d      <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rd    <= 1'b0;
            rmw_word  <= sel_word;
            rmw_wdata <= data.wdata;
            rmw_be    <= data.be;
        end else begin
            state   <= accept ? RSP : IDLE;
            rv_if   <= gnt_if;
            rv_d    <= gnt_d;
            rsp_err <= accept & oor;
            rsp_rd  <= accept & ~oor & ~(gnt_d & data.we);
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: randomized and directed stimulus checked by a scoreboard against a behavioural memory model
module tb_ram_port_arbiter;
    localparam int DEPTH = 2048;
    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
        int          due;
        logic        wr;
        int          word;
        logic [31:0] wval;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ram_we;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    exp_t        q[$];
    int          checks = 0, failures = 0, cyc = 0;
    int          block_cyc = -1, rmw_cyc = -1, rmw_word = 0;
    logic [31:0] rmw_val;
    logic        last_d = 1'b0, prev_rst_low = 1'b0, g_if = 1'b0, g_d = 1'b0;

    ram_port_arbiter_if fetch ();
    ram_port_arbiter_if data ();

    ram_port_arbiter dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .fetch       (fetch),
        .data        (data),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[10:0]] <= ram_wdata;
        else ram_rdata <= mem[ram_addr[10:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] apply_be(input logic [31:0] nw, input logic [31:0] old, input logic [3:0] be);
        logic [31:0] mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (nw & mask) | (old & ~mask);
    endfunction

    function automatic logic [31:0] rand_addr();
        int          r  = $urandom_range(0, 11);
        logic [31:0] lo = 32'($urandom_range(0, 3));
        if (r == 0) return 32'h2000 + 32'($urandom_range(0, 64)) * 4 + lo;
        if (r == 1) return 32'hFFFF_FFFC;
        if (r == 2) return 32'h1FFC + lo;
        return 32'($urandom_range(0, 15)) * 4 + lo;
    endfunction

    task automatic new_data(input logic loads_only);
        int r = $urandom_range(0, 3);
        data.we    = loads_only ? 1'b0 : 1'($urandom_range(0, 1));
        data.be    = r == 0 ? 4'hF : r == 1 ? 4'h0 : 4'($urandom);
        data.addr  = rand_addr();
        data.wdata = $urandom;
    endtask

    // Monitor: responses are retired before the same cycle's grant is modelled, so reads see prior stores.
    always @(negedge clk) begin
        exp_t        e;
        logic        ex_if, ex_d, exp_we, in_range, is_st;
        logic [29:0] word;
        logic [31:0] exp_wd;
        if (!rst_n) begin
            check("rst_gnt", 32'({fetch.gnt, data.gnt}), 32'h0);
            check("rst_ram_we", 32'(ram_we), 32'h0);
            if (prev_rst_low) check("rst_rvalid", 32'({fetch.rvalid, data.rvalid}), 32'h0);
            q.delete();
            last_d = 1'b0;
            block_cyc = -1;
            rmw_cyc = -1;
            g_if = 1'b0;
            g_d = 1'b0;
            prev_rst_low = 1'b1;
        end else begin
            prev_rst_low = 1'b0;
            if (q.size() != 0 && q[0].due < cyc) begin
                check("rsp_missing", 32'h0, 32'h1);
                void'(q.pop_front());
            end
            if (fetch.rvalid || data.rvalid) begin
                if (q.size() == 0) check("rsp_unexpected", 32'({fetch.rvalid, data.rvalid}), 32'h0);
                else begin
                    e = q.pop_front();
                    check("rvalid_port", 32'({fetch.rvalid, data.rvalid}), e.port ? 32'h1 : 32'h2);
                    check("rsp_cycle", 32'(cyc), 32'(e.due));
                    check("rdata", e.port ? data.rdata : fetch.rdata, e.rdata);
                    check("err", 32'(e.port ? data.err : fetch.err), 32'(e.err));
                    if (e.wr) ref_mem[e.word] = e.wval;
                end
            end else check("idle_rsp", fetch.rdata | data.rdata | 32'({fetch.err, data.err}), 32'h0);
            ex_if = 1'b0;
            ex_d = 1'b0;
            if (cyc != block_cyc) begin
                if (fetch.req && data.req) begin
                    ex_d = !last_d;
                    ex_if = last_d;
                end else begin
                    ex_if = fetch.req;
                    ex_d = data.req;
                end
            end
            check("gnt", 32'({fetch.gnt, data.gnt}), 32'({ex_if, ex_d}));
            g_if = fetch.gnt;
            g_d = data.gnt;
            if (ex_if || ex_d) begin
                last_d = ex_d;
                word = ex_d ? data.addr[31:2] : fetch.addr[31:2];
                in_range = word < 30'(DEPTH);
                is_st = ex_d && data.we;
                e.port = ex_d;
                e.err = !in_range;
                e.due = cyc + 1;
                e.wr = 1'b0;
                e.word = int'(word[10:0]);
                e.wval = 32'h0;
                e.rdata = (!is_st && in_range) ? ref_mem[word[10:0]] : 32'h0;
                exp_we = 1'b0;
                exp_wd = 32'h0;
                if (is_st && in_range && data.be != 4'h0) begin
                    e.wr = 1'b1;
                    e.wval = apply_be(data.wdata, ref_mem[word[10:0]], data.be);
                    if (data.be == 4'hF) begin
                        exp_we = 1'b1;
                        exp_wd = data.wdata;
                    end else begin
                        e.due = cyc + 2;
                        block_cyc = cyc + 1;
                        rmw_cyc = cyc + 1;
                        rmw_word = int'(word[10:0]);
                        rmw_val = e.wval;
                    end
                end
                q.push_back(e);
                check("ram_addr", ram_addr, {2'b0, word});
                check("ram_we", 32'(ram_we), 32'(exp_we));
                if (exp_we) check("ram_wdata", ram_wdata, exp_wd);
            end else if (cyc == rmw_cyc) begin
                check("rmw_we", 32'(ram_we), 32'h1);
                check("rmw_addr", ram_addr, 32'(rmw_word));
                check("rmw_wdata", ram_wdata, rmw_val);
            end else check("ram_idle", ram_addr | ram_wdata | 32'(ram_we), 32'h0);
        end
    end

    task automatic d_op(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
        bit done = 0;
        @(posedge clk);
        #1;
        data.req = 1'b1;
        data.we = we;
        data.be = be;
        data.addr = addr;
        data.wdata = wdata;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk);
            done = g_d;
        end
        if (!done) check("d_gnt_timeout", 32'h0, 32'h1);
        #1 data.req = 1'b0;
    endtask

    initial begin
        int nmis;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        fetch.we = 1'b0;
        fetch.be = 4'h0;
        fetch.wdata = 32'h0;
        fetch.req = 1'b1;
        fetch.addr = 32'h0;
        data.req = 1'b1;
        new_data(1'b1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (g_if) fetch.addr = rand_addr();
            if (g_d) new_data(1'b1);
        end
        fetch.req = 1'b0;
        data.req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        fetch.req = 1'b1;
        fetch.addr = 32'h0;
        for (int n = 0, i = 0; n < 3 && i < 20; i++) begin
            @(posedge clk);
            #1;
            if (g_if) begin
                n++;
                fetch.addr = 32'(n) * 4;
                if (n == 3) fetch.req = 1'b0;
            end
        end
        fetch.req = 1'b0;
        d_op(1'b1, 4'hF, 32'h10, 32'hAABBCCDD);
        d_op(1'b1, 4'b0101, 32'h10, 32'h11223344);
        repeat (3) @(posedge clk);
        check("merge_word4", mem[4], 32'hAA22CC44);
        d_op(1'b0, 4'h0, 32'h10, 32'h0);
        d_op(1'b0, 4'h0, 32'h2000, 32'h0);
        repeat (2) @(posedge clk);
        d_op(1'b1, 4'b0011, 32'h14, 32'h5555_5555);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        check("rst_rmw_word5", mem[5], ref_mem[5]);
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            if (!fetch.req || g_if) begin
                fetch.req = $urandom_range(0, 3) != 0;
                fetch.addr = rand_addr();
            end
            if (!data.req || g_d) begin
                data.req = $urandom_range(0, 3) != 0;
                new_data(1'b0);
            end
        end
        fetch.req = 1'b0;
        data.req = 1'b0;
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("drain", 32'(q.size()), 32'h0);
        nmis = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) nmis++;
        check("mem_final", 32'(nmis), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        check("watchdog", 32'h0, 32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
